add_share_arb: RTL

Two-requester front end for the shared 32-bit combinational adder. Arbitrates round-robin between two valid/ready operand ports, drives the single adder instance, and registers the result into a one-entry response buffer tagged with the requester id. Sits between the lab's operand sources (switch/UART front ends) and the adder, so one adder serves several consumers without duplication.

---
 rtl/add_share_arb_pkg.sv | 21 ++
 rtl/add_share_arb_rr_arb2.sv | 26 ++
 rtl/add_share_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/add_share_arb_pkg.sv
// Shared definitions for the two-requester adder front end: default widths,
// buffer FSM encoding and requester id constants.
package add_share_arb_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Index of the winning requester for a one-hot two-way grant.
    function automatic logic grant_index(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/add_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not granted last. Purely combinational, one-hot out.
module rr_arb2
    import add_share_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (valid0 && valid1) begin
                gnt = (last_grant == REQ_ID1) ? 2'b01 : 2'b10;
            end else if (valid0) begin
                gnt = 2'b01;
            end else if (valid1) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin front end sharing one adder between two valid/ready requesters,
// with a one-entry response buffer tagged by requester id.
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

    logic             slot_free;
    logic [1:0]       gnt;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    // The slot can be refilled in the same cycle the consumer drains it;
    // gating with rst_n keeps both readys low while reset is asserted.
    assign slot_free = (state_q == ST_IDLE) || rsp_ready;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .enable     (slot_free && rst_n),
        .gnt        (gnt)
    );

    assign accept     = |gnt;
    assign sel        = grant_index(gnt);
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign op_a = sel ? req1_a : req0_a;
    assign op_b = sel ? req1_b : req0_b;

    assign {add_carry, add_sum} = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_carry_d  = rsp_carry_q;
        gnt_cnt0_d   = gnt_cnt0_q;
        gnt_cnt1_d   = gnt_cnt1_q;
        if (accept) begin
            state_d      = ST_FULL;
            last_grant_d = sel;
            rsp_id_d     = sel;
            rsp_sum_d    = add_sum;
            rsp_carry_d  = add_carry;
            if (sel == REQ_ID1) begin
                gnt_cnt1_d = gnt_cnt1_q + CNT_W'(1);
            end else begin
                gnt_cnt0_d = gnt_cnt0_q + CNT_W'(1);
            end
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_ID1;
            rsp_id_q     <= REQ_ID0;
            rsp_sum_q    <= '0;
            rsp_carry_q  <= 1'b0;
            gnt_cnt0_q   <= '0;
            gnt_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_carry_q  <= rsp_carry_d;
            gnt_cnt0_q   <= gnt_cnt0_d;
            gnt_cnt1_q   <= gnt_cnt1_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;

endmodule
